// File: rtl/onewire_pkg.sv
// Shared 1-wire timing defaults and state encoding for the master and slave blocks.
package onewire_pkg;

    localparam int unsigned OW_FRQ   = 24000000;
    localparam int unsigned OW_T_SMP = 30;
    localparam int unsigned OW_T_RST = 400;
    localparam int unsigned OW_T_PDH = 30;
    localparam int unsigned OW_T_PDL = 120;
    localparam int unsigned OW_CNT_W = 10;

    typedef enum logic [2:0] {
        IDLE,
        SLOT,
        REC,
        RST,
        PDW,
        PDL
    } ow_state_e;

endpackage

// File: rtl/onewire_tick.sv
// 1 us prescaler; a restart realigns the tick phase to the latest bus edge.
module onewire_tick #(
    parameter int unsigned DIV = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic restart_i,
    output logic tick_o
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0] pre_q, pre_d;
    logic          wrap;

    assign wrap   = (pre_q == PW'(DIV - 1));
    assign tick_o = wrap & ~restart_i;

    always_comb begin
        pre_d = pre_q + 1'b1;
        if (restart_i || wrap) pre_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) pre_q <= '0;
        else     pre_q <= pre_d;
    end

endmodule

// File: rtl/onewire_slave.sv
// 1-wire slave responder: reset detection, presence pulse, and LSB-first byte slots.
module onewire_slave
    import onewire_pkg::*;
#(
    parameter int unsigned FRQ   = OW_FRQ,
    parameter int unsigned T_SMP = OW_T_SMP,
    parameter int unsigned T_RST = OW_T_RST,
    parameter int unsigned T_PDH = OW_T_PDH,
    parameter int unsigned T_PDL = OW_T_PDL
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       owr_i,
    output logic       owr_oe,
    output logic       rst_det,
    output logic [7:0] rx_dat,
    output logic       rx_vld,
    input  logic [7:0] tx_dat,
    input  logic       tx_vld,
    output logic       tx_rdy
);

    localparam int unsigned         DIV   = FRQ / 1000000;
    localparam logic [OW_CNT_W-1:0] C_SMP = OW_CNT_W'(T_SMP);
    localparam logic [OW_CNT_W-1:0] C_RST = OW_CNT_W'(T_RST);
    localparam logic [OW_CNT_W-1:0] C_PDH = OW_CNT_W'(T_PDH);
    localparam logic [OW_CNT_W-1:0] C_PDL = OW_CNT_W'(T_PDL);

    ow_state_e           state_q, state_d;
    logic                s1_q, s2_q, prev_q;
    logic [OW_CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]          bit_q, bit_d;
    logic [7:0]          shr_q, shr_d;
    logic [7:0]          txb_q, txb_d;
    logic                txl_q, txl_d;
    logic                oe_q, oe_d;
    logic                rst_det_q, rst_det_d;
    logic [7:0]          rx_dat_q, rx_dat_d;
    logic                rx_vld_q, rx_vld_d;
    logic                fall, rise, tick;

    assign fall = prev_q & ~s2_q;
    assign rise = ~prev_q & s2_q;

    onewire_tick #(.DIV(DIV)) u_tick (
        .clk      (clk),
        .rst      (rst),
        .restart_i(fall),
        .tick_o   (tick)
    );

    assign owr_oe  = oe_q;
    assign rst_det = rst_det_q;
    assign rx_dat  = rx_dat_q;
    assign rx_vld  = rx_vld_q;
    assign tx_rdy  = ~txl_q && (bit_q == '0) && (state_q == IDLE || state_q == REC);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shr_d     = shr_q;
        txb_d     = txb_q;
        txl_d     = txl_q;
        oe_d      = oe_q;
        rst_det_d = 1'b0;
        rx_dat_d  = rx_dat_q;
        rx_vld_d  = 1'b0;

        if (tick && cnt_q != '1) cnt_d = cnt_q + 1'b1;
        if (tx_vld && tx_rdy) begin
            txl_d = 1'b1;
            txb_d = tx_dat;
        end

        case (state_q)
            IDLE: begin
                if (fall) begin
                    cnt_d   = '0;
                    state_d = SLOT;
                    if (txl_q && !txb_q[bit_q]) oe_d = 1'b1;
                end
            end
            SLOT: begin
                if (cnt_q == C_SMP) begin
                    oe_d    = 1'b0;
                    bit_d   = bit_q + 1'b1;
                    state_d = REC;
                    if (!txl_q) shr_d = {s2_q, shr_q[7:1]};
                    if (bit_q == 3'd7) begin
                        if (txl_q) begin
                            txl_d = 1'b0;
                        end else begin
                            rx_dat_d = {s2_q, shr_q[7:1]};
                            rx_vld_d = 1'b1;
                        end
                    end
                end
            end
            REC: begin
                if (s2_q)                state_d = IDLE;
                else if (cnt_q >= C_RST) state_d = RST;
            end
            // Held every cycle in RST, so a byte accepted on the entry cycle is dropped next cycle.
            RST: begin
                bit_d = '0;
                shr_d = '0;
                txl_d = 1'b0;
                oe_d  = 1'b0;
                if (rise) begin
                    rst_det_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = PDW;
                end
            end
            PDW: begin
                if (cnt_q == C_PDH) begin
                    oe_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = PDL;
                end
            end
            PDL: begin
                if (cnt_q == C_PDL) begin
                    oe_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            s1_q      <= 1'b1;
            s2_q      <= 1'b1;
            prev_q    <= 1'b1;
            cnt_q     <= '0;
            bit_q     <= '0;
            shr_q     <= '0;
            txb_q     <= '0;
            txl_q     <= 1'b0;
            oe_q      <= 1'b0;
            rst_det_q <= 1'b0;
            rx_dat_q  <= '0;
            rx_vld_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            s1_q      <= owr_i;
            s2_q      <= s1_q;
            prev_q    <= s2_q;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shr_q     <= shr_d;
            txb_q     <= txb_d;
            txl_q     <= txl_d;
            oe_q      <= oe_d;
            rst_det_q <= rst_det_d;
            rx_dat_q  <= rx_dat_d;
            rx_vld_q  <= rx_vld_d;
        end
    end

endmodule

// File: tb/tb_onewire_slave.sv
// Bench for onewire_slave: master waveforms against a slot-level model of expected bus behaviour.
module tb_onewire_slave;

    localparam int US    = 4;
    localparam int FRQ   = US * 1000000;
    localparam int T_SMP = 30;
    localparam int T_RST = 400;
    localparam int T_PDH = 30;
    localparam int T_PDL = 120;
    localparam int TOL   = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       master_low = 1'b0;
    logic       owr_i;
    logic       owr_oe;
    logic       rst_det;
    logic [7:0] rx_dat;
    logic       rx_vld;
    logic [7:0] tx_dat = 8'h00;
    logic       tx_vld = 1'b0;
    logic       tx_rdy;

    assign owr_i = ~(master_low | owr_oe);

    onewire_slave #(.FRQ(FRQ)) dut (
        .clk    (clk),
        .rst    (rst),
        .owr_i  (owr_i),
        .owr_oe (owr_oe),
        .rst_det(rst_det),
        .rx_dat (rx_dat),
        .rx_vld (rx_vld),
        .tx_dat (tx_dat),
        .tx_vld (tx_vld),
        .tx_rdy (tx_rdy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    function automatic void check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, got, exp, cyc);
        end
    endfunction

    // Model state: written only by the stimulus process.
    int         win_s[$];
    int         win_e[$];
    int         rd_q[$];
    logic [7:0] rx_q[$];
    logic       m_tx_loaded = 1'b0;
    logic [7:0] m_tx  = 8'h00;
    logic [7:0] m_shr = 8'h00;
    int         m_bit = 0;
    logic       chk_en = 1'b0;

    // Observations: written only by the compare process.
    int         rx_idx = 0;
    int         rx_cnt = 0;
    logic [7:0] last_rx = 8'h00;
    int         rd_cnt = 0;
    int         oe_cnt = 0;

    function automatic void model_reset();
        m_bit       = 0;
        m_shr       = 8'h00;
        m_tx_loaded = 1'b0;
    endfunction

    // A master low of duration us starting at cycle f, judged from the protocol rules.
    function automatic void model_fall(input int f, input int us);
        int r;
        if (us >= T_RST) begin
            model_reset();
            r = f + us * US;
            rd_q.push_back(r + 3);
            win_s.push_back(r + 3 + T_PDH * US);
            win_e.push_back(r + 3 + (T_PDH + T_PDL) * US);
        end else if (m_tx_loaded) begin
            if (!m_tx[m_bit]) begin
                win_s.push_back(f + 3);
                win_e.push_back(f + 3 + T_SMP * US);
            end
            m_bit++;
            if (m_bit == 8) begin
                m_bit       = 0;
                m_tx_loaded = 1'b0;
            end
        end else begin
            m_shr = {(us < T_SMP) ? 1'b1 : 1'b0, m_shr[7:1]};
            m_bit++;
            if (m_bit == 8) begin
                rx_q.push_back(m_shr);
                m_bit = 0;
            end
        end
    endfunction

    always @(negedge clk) begin
        logic core, wide, exp_rd;
        if (chk_en) begin
            core = 1'b0;
            wide = 1'b0;
            for (int i = 0; i < win_s.size(); i++) begin
                if (cyc >= win_s[i] + TOL && cyc <= win_e[i] - TOL) core = 1'b1;
                if (cyc >= win_s[i] - TOL && cyc <= win_e[i] + TOL) wide = 1'b1;
            end
            if (core)       check("owr_oe_active", int'(owr_oe), 1);
            else if (!wide) check("owr_oe_idle", int'(owr_oe), 0);

            exp_rd = 1'b0;
            foreach (rd_q[i]) if (rd_q[i] == cyc) exp_rd = 1'b1;
            check("rst_det", int'(rst_det), int'(exp_rd));
            if (rst_det) rd_cnt++;
            if (owr_oe)  oe_cnt++;

            if (rx_vld) begin
                rx_cnt++;
                last_rx = rx_dat;
                if (rx_idx >= rx_q.size()) begin
                    check("rx_vld_unexpected", 1, 0);
                end else begin
                    check("rx_dat", int'(rx_dat), int'(rx_q[rx_idx]));
                    rx_idx++;
                end
            end
        end
    end

    task automatic bus_pulse(input int us, input int gap_us);
        @(negedge clk);
        master_low = 1'b1;
        model_fall(cyc, us);
        repeat (us * US) @(negedge clk);
        master_low = 1'b0;
        repeat (gap_us * US) @(negedge clk);
    endtask

    task automatic write_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            if (b[i]) bus_pulse(6, 64);
            else      bus_pulse(60, 10);
        end
    endtask

    task automatic load_tx(input logic [7:0] b);
        int n = 0;
        while (!tx_rdy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("tx_rdy_wait", int'(tx_rdy), 1);
        tx_dat = b;
        tx_vld = 1'b1;
        @(negedge clk);
        tx_vld      = 1'b0;
        m_tx        = b;
        m_tx_loaded = 1'b1;
        m_bit       = 0;
        check("tx_rdy_after_load", int'(tx_rdy), 0);
    endtask

    initial begin
        int         oe0;
        logic [7:0] mask;
        int         c;

        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_owr_oe", int'(owr_oe), 0);
        check("reset_rst_det", int'(rst_det), 0);
        check("reset_rx_dat", int'(rx_dat), 0);
        check("reset_rx_vld", int'(rx_vld), 0);
        check("reset_tx_rdy", int'(tx_rdy), 1);
        chk_en = 1'b1;

        // Bus reset with presence.
        bus_pulse(480, 250);
        check("rst_det_count_1", rd_cnt, 1);

        // Write 0xA5; the slave must never pull the bus.
        oe0 = oe_cnt;
        write_byte(8'hA5);
        check("write_no_oe", oe_cnt - oe0, 0);
        check("rx_count_1", rx_cnt, 1);
        check("rx_last_A5", int'(last_rx), 8'hA5);

        // Read 0x3C: pull-down only in slots 0, 1, 6, 7.
        load_tx(8'h3C);
        mask = 8'h00;
        for (int i = 0; i < 8; i++) begin
            oe0 = oe_cnt;
            bus_pulse(6, 64);
            mask[i] = (oe_cnt != oe0);
        end
        check("read_oe_slots", int'(mask), 8'hC3);
        check("tx_rdy_after_byte", int'(tx_rdy), 1);

        // Mid-byte reset, then a clean byte.
        bus_pulse(6, 64);
        bus_pulse(60, 10);
        bus_pulse(6, 64);
        bus_pulse(500, 250);
        write_byte(8'h81);
        check("rx_count_2", rx_cnt, 2);
        check("rx_last_81", int'(last_rx), 8'h81);
        check("rst_det_count_2", rd_cnt, 2);

        // Presence aborted by rst, then a normal bus reset.
        @(negedge clk);
        master_low = 1'b1;
        model_fall(cyc, 480);
        repeat (480 * US) @(negedge clk);
        master_low = 1'b0;
        repeat (3 + 60 * US) @(negedge clk);
        check("oe_in_presence", int'(owr_oe), 1);
        rst = 1'b1;
        c   = cyc;
        win_e[win_e.size() - 1] = c;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        check("oe_after_rst", int'(owr_oe), 0);
        repeat (100 * US) @(negedge clk);
        bus_pulse(480, 250);
        check("rst_det_count_4", rd_cnt, 4);

        // Long zero just under the reset threshold, then just over it.
        bus_pulse(390, 20);
        check("long_zero_no_rst", rd_cnt, 4);
        bus_pulse(410, 250);
        check("rst_det_count_5", rd_cnt, 5);
        check("rx_count_final", rx_cnt, 2);
        check("rx_pending", rx_q.size() - rx_idx, 0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
